// File: rtl/serial_parity_checker.sv
// Serial parity checker: takes DATA_BITS data bits (LSB first) plus one parity bit,
// rebuilds the word and flags a parity mismatch. Optional ERR_COUNT_EN adds a saturating error counter.
`timescale 1ns/1ps
module serial_parity_checker #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
`ifdef ERR_COUNT_EN
  ,
  parameter int ERR_CNT_W  = 8
`endif
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 IN_VALID,
  input  logic                 IN_BIT,
  output logic                 IN_READY,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DATA_BITS-1:0] OUT_DATA,
  output logic                 OUT_ERR,
  output logic                 BUSY
`ifdef ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0] ERR_CNT
`endif
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if (DATA_BITS < 2 || DATA_BITS > 32) begin : g_cfg_err
    $fatal(1, "serial_parity_checker: DATA_BITS=%0d outside 2..32", DATA_BITS);
  end

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_shadow;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_err;
  logic                 r_out_valid;

  logic w_accept;
  logic w_data_take;
  logic w_par_take;
  logic w_release;
  logic w_start;
  logic w_last;

  assign IN_READY    = (r_state == S_DATA) || (r_state == S_PARITY);
  assign BUSY        = (r_state != S_IDLE);
  assign OUT_VALID   = r_out_valid;
  assign OUT_DATA    = r_out_data;
  assign OUT_ERR     = r_out_err;

  assign w_accept    = IN_VALID && IN_READY;
  assign w_data_take = w_accept && (r_state == S_DATA);
  assign w_par_take  = w_accept && (r_state == S_PARITY);
  assign w_release   = r_out_valid && OUT_READY;
  assign w_last      = (r_cnt == CNT_W'(DATA_BITS - 1));
  // START only counts in IDLE, or in DONE on the very cycle the result is handed off
  assign w_start     = START && ((r_state == S_IDLE) || ((r_state == S_DONE) && w_release));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (START) w_next = S_DATA;
      S_DATA:   if (w_data_take && w_last) w_next = S_PARITY;
      S_PARITY: if (w_par_take) w_next = S_DONE;
      S_DONE:   if (w_release) w_next = START ? S_DATA : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc       <= 1'b0;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // seeding with PARITY_ODD makes a correct frame XOR down to zero in both modes
      if (w_start) begin
        r_acc <= PARITY_ODD;
        r_cnt <= '0;
      end else if (w_data_take) begin
        r_shadow[r_cnt] <= IN_BIT;
        r_acc           <= r_acc ^ IN_BIT;
        r_cnt           <= r_cnt + CNT_W'(1);
      end

      if (w_par_take) begin
        r_out_err   <= r_acc ^ IN_BIT;
        r_out_data  <= r_shadow;
        r_out_valid <= 1'b1;
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign ERR_CNT = r_err_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err_cnt <= '0;
    end else if (w_par_take && (r_acc ^ IN_BIT) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end
`endif

endmodule
